serial_divide_su: RTL and testbench
===================================

Name: serial_divide_su

Overview:
Parametrised successor to the unsigned serial divider. It computes one quotient bit per enabled clock using restoring division, and adds the following:
- per-operation signed/unsigned mode
- remainder output
- divide-by-zero and overflow flags
- busy/done handshake

It sits beside the datapath as a low-area multi-cycle divider. It is gated by a shared clock enable, the same way its predecessor is.

Parameters:
- M_PP, 16, dividend width (bits).
- N_PP, 8, divisor and remainder width (bits); N_PP <= M_PP.
- R_PP, 0, extra fractional quotient bits. The dividend is internally extended by R_PP zero LSBs.
- COUNT_WIDTH_PP, 5, iteration counter width; must hold M_PP+R_PP.

Ports:
- clk_i  in  1  Clock. One clock domain.
- rst_i  in  1  Reset, synchronous, active-high.
- clk_en_i  in  1  Clock enable. When 0, all state and outputs hold.
- start_i  in  1  Start request. Sampled on an enabled edge while idle.
- signed_i  in  1  1 = two's-complement operands; captured with start_i.
- dividend_i  in  M_PP  Dividend; captured with start_i.
- divisor_i  in  N_PP  Divisor; captured with start_i.
- busy_o  out  1  High from the capture edge until the completion edge.
- done_o  out  1  High for exactly one enabled cycle after completion.
- quotient_o  out  M_PP+R_PP  Quotient. Held until the next completion.
- remainder_o  out  N_PP  Remainder. Held until the next completion.
- div_by_zero_o  out  1  Valid with done_o; held.
- overflow_o  out  1  Valid with done_o; held.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge, regardless of clk_en_i):
  - state = IDLE
  - busy_o = done_o = div_by_zero_o = overflow_o = 0
  - quotient_o = 0, remainder_o = 0
  - A reset mid-operation aborts it; no done_o is produced.
- Only edges with clk_en_i=1 advance state. done_o stays high until the next enabled edge.
- IDLE:
  - start_i=1 on an enabled edge (capture edge E0): latch operands and mode, set busy_o=1.
  - If divisor == 0, go to FIXUP. Otherwise go to CALC with counter = M_PP+R_PP.
- CALC:
  - Each enabled edge: shift the partial remainder left with the next dividend bit, trial-subtract |divisor|, set the quotient bit, decrement the counter.
  - After M_PP+R_PP steps (edges E1..E(M_PP+R_PP)), go to FIXUP.
- FIXUP (one enabled edge):
  - Apply signs.
  - Write quotient_o, remainder_o and the flags.
  - Set done_o=1, busy_o=0, return to IDLE.
- Latency: done_o rises on edge E(M_PP+R_PP+1). For the divide-by-zero case it rises on E1.
- Signed mode:
  - Operate on magnitudes, with the dividend magnitude in M_PP+1 bits internally.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
- Unsigned mode: raw operand values are used.
- Divide by zero:
  - quotient_o = all ones, remainder_o = 0.
  - div_by_zero_o = 1, overflow_o = 0.
- Overflow:
  - Signed mode only.
  - Set when the true quotient does not fit in signed M_PP+R_PP bits. Example: -2^(M_PP-1) / -1 with R_PP=0.
  - quotient_o = wrapped low bits; overflow_o = 1.
- start_i while busy is ignored: no re-capture, no queueing.
- start_i on the same enabled edge that FIXUP completes is ignored. A new start is accepted from the next enabled edge.
- Outputs change only on FIXUP or reset.

Decomposition:
- Package serial_divide_pkg:
  - state enum {IDLE, CALC, FIXUP}
  - localparams Q_W = M_PP+R_PP and A_W = N_PP+1 (accumulator width)
  - function abs_val
  - function cond_negate
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, next bit, |divisor|.
  - Outputs: new remainder, quotient bit.
- The top level holds the FSM, counter and registers. Expected size is 150-250 lines.

Test Plan:
1. Unsigned 0 / 255 -> quotient_o=0, remainder_o=0, flags 0. done_o rises exactly 17 enabled edges after capture; busy_o high in between.
2. Unsigned 1000 / 7 -> quotient_o=142, remainder_o=6. Signed -1000 / 7 -> quotient_o=0xFF72 (-142), remainder_o=0xFA (-6). Signed 1000 / -7 -> 0xFF72, remainder_o=6.
3. Divide by zero: 1234 / 0 -> quotient_o=0xFFFF, remainder_o=0, div_by_zero_o=1, done_o on E1.
4. Signed -32768 / -1 -> quotient_o=0x8000, overflow_o=1. R_PP=4, unsigned 1 / 3 -> quotient_o=5 (0.0101b).
5. clk_en_i toggling 1/0 -> identical results, done_o after 34 clocks. start_i pulses during CALC are ignored (result is for the first operands).
6. rst_i asserted at CALC step 8 -> next edge busy_o=0, all outputs 0, no done_o. A fresh start then completes correctly.

Source files
------------

// File: rtl/serial_divide_pkg.sv
// Shared types and helpers for the serial restoring divider.
// Helpers work on a 64-bit container and mask the result to the requested width.
package serial_divide_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

   // Widths for the default configuration; instances derive their own from parameters.
   localparam int unsigned Q_W   = 16 + 0;
   localparam int unsigned A_W   = 8 + 1;
   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
      if (w >= MAX_W) return {MAX_W{1'b1}};
      return (MAX_W'(1) << w) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                     input logic neg,
                                                     input int unsigned w);
      return (neg ? (~v + MAX_W'(1)) : v) & width_mask(w);
   endfunction

   // Magnitude of a w-bit value; the most negative value maps to 2^(w-1).
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                                 input logic is_signed,
                                                 input int unsigned w);
      return cond_negate(v, is_signed && v[w-1], w);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
// Partial remainder is always below the divisor, so it fits N_PP bits on both sides.
module div_step
   import serial_divide_pkg::*;
#(
   parameter int unsigned N_PP = 8
) (
   input  logic [N_PP-1:0] rem_i,
   input  logic            bit_i,
   input  logic [N_PP-1:0] dvs_i,
   output logic [N_PP-1:0] rem_o,
   output logic            qbit_o
);

   logic [N_PP:0]   shifted;
   logic [N_PP-1:0] diff;

   assign shifted = {rem_i, bit_i};
   // Only the low bits of the difference are needed: when the subtract is kept it is < dvs_i.
   assign diff    = shifted[N_PP-1:0] - dvs_i;
   assign qbit_o  = (shifted >= {1'b0, dvs_i});
   assign rem_o   = qbit_o ? diff : shifted[N_PP-1:0];

endmodule

// File: rtl/serial_divide_su.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per enabled clock.
// Capture edge, M_PP+R_PP step edges, one fixup edge; divide-by-zero skips the steps.
module serial_divide_su
   import serial_divide_pkg::*;
#(
   parameter int unsigned M_PP           = 16,
   parameter int unsigned N_PP           = 8,
   parameter int unsigned R_PP           = 0,
   parameter int unsigned COUNT_WIDTH_PP = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clk_en_i,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [M_PP-1:0]      dividend_i,
   input  logic [N_PP-1:0]      divisor_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [M_PP+R_PP-1:0] quotient_o,
   output logic [N_PP-1:0]      remainder_o,
   output logic                 div_by_zero_o,
   output logic                 overflow_o
);

   localparam int unsigned QW = M_PP + R_PP;

   state_e                    state_q;
   logic [COUNT_WIDTH_PP-1:0] cnt_q;
   logic                      sgn_q, dvd_neg_q, dvs_neg_q, dbz_q;
   logic [N_PP-1:0]           dvs_q, rem_q;
   logic [QW-1:0]             sh_q;
   logic                      busy_q, done_q, dbz_out_q, ovf_q;
   logic [QW-1:0]             quo_q;
   logic [N_PP-1:0]           rmd_q;

   logic [M_PP:0]   dvd_ext;
   logic [M_PP-1:0] dvd_mag_d;
   logic [N_PP-1:0] dvs_mag_d;
   logic [N_PP-1:0] rem_d;
   logic            qbit_d;
   logic            q_neg_d;
   logic [QW-1:0]   quo_fix_d;
   logic [N_PP-1:0] rem_fix_d;
   logic            ovf_d;

   assign dvd_ext   = {signed_i & dividend_i[M_PP-1], dividend_i};
   assign dvd_mag_d = M_PP'(abs_val({{(MAX_W-M_PP-1){1'b0}}, dvd_ext}, signed_i, M_PP + 1));
   assign dvs_mag_d = N_PP'(abs_val({{(MAX_W-N_PP){1'b0}}, divisor_i}, signed_i, N_PP));

   div_step #(.N_PP(N_PP)) u_step (
      .rem_i  (rem_q),
      .bit_i  (sh_q[QW-1]),
      .dvs_i  (dvs_q),
      .rem_o  (rem_d),
      .qbit_o (qbit_d)
   );

   assign q_neg_d   = sgn_q & (dvd_neg_q ^ dvs_neg_q);
   assign quo_fix_d = QW'(cond_negate({{(MAX_W-QW){1'b0}}, sh_q}, q_neg_d, QW));
   assign rem_fix_d = N_PP'(cond_negate({{(MAX_W-N_PP){1'b0}}, rem_q}, sgn_q & dvd_neg_q, N_PP));
   // A negative result may reach -2^(QW-1); a positive one must stay below 2^(QW-1).
   assign ovf_d     = sgn_q & (q_neg_d ? (sh_q[QW-1] & (|sh_q[QW-2:0])) : sh_q[QW-1]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sgn_q     <= 1'b0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         dvs_q     <= '0;
         rem_q     <= '0;
         sh_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         ovf_q     <= 1'b0;
         quo_q     <= '0;
         rmd_q     <= '0;
      end else if (clk_en_i) begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  sgn_q     <= signed_i;
                  dvd_neg_q <= signed_i & dividend_i[M_PP-1];
                  dvs_neg_q <= signed_i & divisor_i[N_PP-1];
                  dbz_q     <= (divisor_i == '0);
                  dvs_q     <= dvs_mag_d;
                  rem_q     <= '0;
                  sh_q      <= QW'(dvd_mag_d) << R_PP;
                  cnt_q     <= COUNT_WIDTH_PP'(QW);
                  busy_q    <= 1'b1;
                  state_q   <= (divisor_i == '0) ? FIXUP : CALC;
               end
            end
            CALC: begin
               // Dividend bits leave at the top while quotient bits enter at the bottom.
               sh_q  <= {sh_q[QW-2:0], qbit_d};
               rem_q <= rem_d;
               cnt_q <= cnt_q - COUNT_WIDTH_PP'(1);
               if (cnt_q == COUNT_WIDTH_PP'(1)) state_q <= FIXUP;
            end
            FIXUP: begin
               if (dbz_q) begin
                  quo_q     <= '1;
                  rmd_q     <= '0;
                  dbz_out_q <= 1'b1;
                  ovf_q     <= 1'b0;
               end else begin
                  quo_q     <= quo_fix_d;
                  rmd_q     <= rem_fix_d;
                  dbz_out_q <= 1'b0;
                  ovf_q     <= ovf_d;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quo_q;
   assign remainder_o   = rmd_q;
   assign div_by_zero_o = dbz_out_q;
   assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_serial_divide_su.sv
// Directed bench for serial_divide_su: default instance plus an R_PP=4 instance on shared inputs.
module tb_serial_divide_su;

   logic        clk = 1'b0;
   logic        rst, clk_en, start, sgn;
   logic [15:0] dvd;
   logic [7:0]  dvs;

   logic        busy_a, done_a, dbz_a, ovf_a;
   logic [15:0] q_a;
   logic [7:0]  r_a;
   logic        busy_b, done_b, dbz_b, ovf_b;
   logic [19:0] q_b;
   logic [7:0]  r_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_divide_su #(.M_PP(16), .N_PP(8), .R_PP(0), .COUNT_WIDTH_PP(5)) dut_a (
      .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .start_i(start), .signed_i(sgn),
      .dividend_i(dvd), .divisor_i(dvs), .busy_o(busy_a), .done_o(done_a),
      .quotient_o(q_a), .remainder_o(r_a), .div_by_zero_o(dbz_a), .overflow_o(ovf_a)
   );

   serial_divide_su #(.M_PP(16), .N_PP(8), .R_PP(4), .COUNT_WIDTH_PP(5)) dut_b (
      .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .start_i(start), .signed_i(sgn),
      .dividend_i(dvd), .divisor_i(dvs), .busy_o(busy_b), .done_o(done_b),
      .quotient_o(q_b), .remainder_o(r_b), .div_by_zero_o(dbz_b), .overflow_o(ovf_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Start one operation and wait (bounded) for done on the default instance.
   task automatic do_op(input logic s, input logic [15:0] a, input logic [7:0] b,
                        input bit toggle, input bit pulse,
                        output int lat, output bit busy_ok);
      @(negedge clk);
      sgn = s; dvd = a; dvs = b; start = 1'b1; clk_en = 1'b1;
      tick();
      start = 1'b0;
      busy_ok = busy_a;
      lat = 0;
      while (!done_a && lat < 200) begin
         clk_en = !toggle || ((lat + 1) % 2 == 0);
         if (pulse && lat == 5) begin start = 1'b1; dvd = 16'h7777; dvs = 8'd3; end
         if (pulse && lat == 7) start = 1'b0;
         tick();
         lat++;
         if (!done_a && !busy_a) busy_ok = 1'b0;
      end
      clk_en = 1'b1;
      start  = 1'b0;
   endtask

   task automatic run(input string tag, input logic s, input logic [15:0] a, input logic [7:0] b,
                      input bit toggle, input bit pulse,
                      input logic [15:0] eq, input logic [7:0] er,
                      input logic edbz, input logic eovf, input int elat);
      int lat;
      bit bok;
      do_op(s, a, b, toggle, pulse, lat, bok);
      check({tag, ".lat"}, lat, elat);
      check({tag, ".done"}, done_a, 1'b1);
      check({tag, ".busy_during"}, bok, 1'b1);
      check({tag, ".busy_end"}, busy_a, 1'b0);
      check({tag, ".q"}, q_a, eq);
      check({tag, ".r"}, r_a, er);
      check({tag, ".dbz"}, dbz_a, edbz);
      check({tag, ".ovf"}, ovf_a, eovf);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy_a || busy_b) && n < 100) begin
         tick();
         n++;
      end
      check({tag, ".idle"}, busy_a | busy_b, 1'b0);
   endtask

   initial begin
      int  lb;
      bit  saw_done;
      rst = 1'b1; clk_en = 1'b0; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst.busy", busy_a, 1'b0);
      check("rst.done", done_a, 1'b0);
      check("rst.q", q_a, 16'h0);
      check("rst.r", r_a, 8'h0);
      check("rst.flags", {dbz_a, ovf_a}, 2'b00);
      check("rst.qb", q_b, 20'h0);

      run("u0_255", 1'b0, 16'd0, 8'd255, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 17);
      tick();
      check("u0_255.done_drop", done_a, 1'b0);

      run("u1000_7", 1'b0, 16'd1000, 8'd7, 1'b0, 1'b0, 16'd142, 8'd6, 1'b0, 1'b0, 17);
      run("sn1000_7", 1'b1, 16'hFC18, 8'd7, 1'b0, 1'b0, 16'hFF72, 8'hFA, 1'b0, 1'b0, 17);
      run("s1000_n7", 1'b1, 16'd1000, 8'hF9, 1'b0, 1'b0, 16'hFF72, 8'h06, 1'b0, 1'b0, 17);
      run("s100_n3", 1'b1, 16'd100, 8'hFD, 1'b0, 1'b0, 16'hFFDF, 8'h01, 1'b0, 1'b0, 17);
      run("dbz", 1'b0, 16'd1234, 8'd0, 1'b0, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1'b0, 1);
      run("ovf", 1'b1, 16'h8000, 8'hFF, 1'b0, 1'b0, 16'h8000, 8'd0, 1'b0, 1'b1, 17);
      run("u_large", 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'h0101, 8'd0, 1'b0, 1'b0, 17);

      wait_idle("frac");
      run("frac_a", 1'b0, 16'd1, 8'd3, 1'b0, 1'b0, 16'd0, 8'd1, 1'b0, 1'b0, 17);
      lb = 0;
      while (!done_b && lb < 50) begin
         tick();
         lb++;
      end
      check("frac.lat_extra", lb, 4);
      check("frac.qb", q_b, 20'd5);
      check("frac.rb", r_b, 8'd1);
      check("frac.flags", {dbz_b, ovf_b}, 2'b00);

      wait_idle("tog");
      run("tog", 1'b0, 16'd1000, 8'd7, 1'b1, 1'b0, 16'd142, 8'd6, 1'b0, 1'b0, 34);
      run("pulse", 1'b0, 16'd1000, 8'd7, 1'b0, 1'b1, 16'd142, 8'd6, 1'b0, 1'b0, 17);

      // Abort mid-operation at CALC step 8.
      wait_idle("abort");
      @(negedge clk);
      sgn = 1'b0; dvd = 16'd5000; dvs = 8'd9; start = 1'b1; clk_en = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("abort.busy_pre", busy_a, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.busy", busy_a, 1'b0);
      check("abort.done", done_a, 1'b0);
      check("abort.q", q_a, 16'h0);
      check("abort.r", r_a, 8'h0);
      check("abort.flags", {dbz_a, ovf_a}, 2'b00);
      saw_done = 1'b0;
      repeat (20) begin
         tick();
         if (done_a) saw_done = 1'b1;
      end
      check("abort.no_done", saw_done, 1'b0);
      run("after_abort", 1'b1, 16'hFC18, 8'd7, 1'b0, 1'b0, 16'hFF72, 8'hFA, 1'b0, 1'b0, 17);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
